// File: rtl/ahb_slave_if_gen_if.sv
// AHB-to-APB bridge front-end bus bundle: AHB request side, APB read-return side,
// and the decoded/pipelined outputs of ahb_slave_if_gen.
// Modports: slave = the bridge front-end, master = whatever drives AHB and consumes outputs.
interface ahb_slave_if_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3
);
    // AHB request side
    logic                hwrite;
    logic                hready_in;
    logic [1:0]          htrans;
    logic [ADDR_W-1:0]   haddr;
    logic [DATA_W-1:0]   hwdata;
    // APB return side
    logic [DATA_W-1:0]   pr_data;
    logic                pr_ready;
    // decode outputs
    logic                valid;
    logic [NUM_SLV-1:0]  sel;
    // final pipeline stage
    logic [ADDR_W-1:0]   haddr_p;
    logic [DATA_W-1:0]   hwdata_p;
    logic                hwrite_p;
    logic [NUM_SLV-1:0]  sel_p;
    logic                valid_p;
    // AHB response side
    logic [DATA_W-1:0]   hr_data;
    logic                hready_out;
    logic                hresp;

    modport slave (
        input  hwrite, hready_in, htrans, haddr, hwdata, pr_data, pr_ready,
        output valid, sel, haddr_p, hwdata_p, hwrite_p, sel_p, valid_p,
        output hr_data, hready_out, hresp
    );

    modport master (
        output hwrite, hready_in, htrans, haddr, hwdata, pr_data, pr_ready,
        input  valid, sel, haddr_p, hwdata_p, hwrite_p, sel_p, valid_p,
        input  hr_data, hready_out, hresp
    );
endinterface

// File: rtl/ahb_slave_if_gen.sv
// Purpose: AHB slave front-end: decodes haddr into NUM_SLV regions, pipelines
//   address/control PIPE_DEPTH stages (write data one stage behind), and drives a
//   two-cycle AHB ERROR response for out-of-range NONSEQ/SEQ transfers.
// Latency: valid/sel/hr_data combinational; *_p outputs PIPE_DEPTH enabled edges.
// Backpressure: pipeline only advances when hready_in=1; hready_out follows pr_ready
//   in IDLE and is forced low in the first error cycle.
// Ports: hclk, hreset (sync, active-high), bus (ahb_slave_if_gen_if.slave).
module ahb_slave_if_gen #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLV    = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                RGN_LOG2   = 26,
    parameter int                PIPE_DEPTH = 2
) (
    input logic               hclk,
    input logic               hreset,
    ahb_slave_if_gen_if.slave bus
);
    localparam int AW1 = ADDR_W + 1;
    // write data trails address by one stage, but always has at least one register
    localparam int DD  = (PIPE_DEPTH > 1) ? PIPE_DEPTH - 1 : 1;

    // Bounds are computed one bit wider so the top of the last region cannot wrap
    localparam logic [AW1-1:0] RGN_LO = {1'b0, BASE_ADDR};
    localparam logic [AW1-1:0] RGN_HI = RGN_LO + (AW1'(NUM_SLV) << RGN_LOG2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [AW1-1:0]     addr_ext;
    logic [AW1-1:0]     rgn_idx;
    logic               in_range;
    logic [NUM_SLV-1:0] sel_c;
    logic               valid_c;
    logic               err_cond;

    // ---------------- address decode ----------------
    always_comb begin
        addr_ext = {1'b0, bus.haddr};
        in_range = (addr_ext >= RGN_LO) && (addr_ext < RGN_HI);
        rgn_idx  = (addr_ext - RGN_LO) >> RGN_LOG2;
        sel_c    = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_c[i] = in_range && (rgn_idx == AW1'(i));
        end
    end

    // Only NONSEQ/SEQ (htrans[1]) qualify; BUSY/IDLE never select or error.
    assign err_cond = bus.hready_in && bus.htrans[1] && !in_range;
    assign valid_c  = bus.hready_in && bus.htrans[1] && in_range && (state != S_ERR1);

    assign bus.valid   = valid_c;
    assign bus.sel     = sel_c;
    assign bus.hr_data = bus.pr_data;

    // ---------------- error FSM: state register ----------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- error FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = err_cond ? S_ERR1 : S_IDLE;
            S_ERR1:  state_nxt = S_ERR2;
            S_ERR2:  state_nxt = err_cond ? S_ERR1 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- error FSM: outputs ----------------
    // Reset masks any in-flight error so the master sees OKAY throughout reset.
    always_comb begin
        bus.hready_out = bus.pr_ready;
        bus.hresp      = 1'b0;
        if (!hreset) begin
            case (state)
                S_ERR1: begin
                    bus.hready_out = 1'b0;
                    bus.hresp      = 1'b1;
                end
                S_ERR2: begin
                    bus.hready_out = 1'b1;
                    bus.hresp      = 1'b1;
                end
                default: begin
                    bus.hready_out = bus.pr_ready;
                    bus.hresp      = 1'b0;
                end
            endcase
        end
    end

    // ---------------- pipeline ----------------
    logic [ADDR_W-1:0]  addr_q  [PIPE_DEPTH];
    logic               write_q [PIPE_DEPTH];
    logic [NUM_SLV-1:0] sel_q   [PIPE_DEPTH];
    logic               vld_q   [PIPE_DEPTH];
    logic [DATA_W-1:0]  data_q  [DD];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                addr_q[k]  <= '0;
                write_q[k] <= 1'b0;
                sel_q[k]   <= '0;
                vld_q[k]   <= 1'b0;
            end
            for (int k = 0; k < DD; k++) begin
                data_q[k] <= '0;
            end
        end else if (bus.hready_in) begin
            // out-of-range already decodes to sel=0/valid=0, so stage 1 takes it as-is
            addr_q[0]  <= bus.haddr;
            write_q[0] <= bus.hwrite;
            sel_q[0]   <= sel_c;
            vld_q[0]   <= valid_c;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                addr_q[k]  <= addr_q[k-1];
                write_q[k] <= write_q[k-1];
                sel_q[k]   <= sel_q[k-1];
                vld_q[k]   <= vld_q[k-1];
            end
            // hwdata arrives in the AHB data phase, one beat after its address
            data_q[0] <= bus.hwdata;
            for (int k = 1; k < DD; k++) begin
                data_q[k] <= data_q[k-1];
            end
        end
    end

    assign bus.haddr_p  = addr_q[PIPE_DEPTH-1];
    assign bus.hwrite_p = write_q[PIPE_DEPTH-1];
    assign bus.sel_p    = sel_q[PIPE_DEPTH-1];
    assign bus.valid_p  = vld_q[PIPE_DEPTH-1];
    assign bus.hwdata_p = data_q[DD-1];

endmodule

// File: tb/tb_ahb_slave_if_gen.sv
// Bench for ahb_slave_if_gen at default parameters (3 regions from 0x8000_0000,
// 64 MiB each, 2 pipeline stages). Stage values are queued when driven and
// compared when they reach the *_p outputs.
module tb_ahb_slave_if_gen;
    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam int          NUM_SLV    = 3;
    localparam int          RGN_LOG2   = 26;
    localparam int          PIPE_DEPTH = 2;
    localparam logic [31:0] BASE       = 32'h8000_0000;
    localparam int          DD         = (PIPE_DEPTH > 1) ? PIPE_DEPTH - 1 : 1;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_slave_if_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

    ahb_slave_if_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE),
        .RGN_LOG2  (RGN_LOG2),
        .PIPE_DEPTH(PIPE_DEPTH)
    ) dut (
        .hclk  (hclk),
        .hreset(hreset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0]        addr;
        logic               wr;
        logic [NUM_SLV-1:0] sel;
        logic               vld;
    } stg_t;

    stg_t        exp_q[$];
    logic [31:0] dat_q[$];
    int          m_state;   // 0 IDLE, 1 ERR1, 2 ERR2
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic m_inrange(input logic [31:0] a);
        longint lo, hi;
        lo = longint'(BASE);
        hi = lo + (longint'(NUM_SLV) << RGN_LOG2);
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    function automatic logic [NUM_SLV-1:0] m_sel(input logic [31:0] a);
        if (!m_inrange(a)) return '0;
        return NUM_SLV'(1) << ((a - BASE) >> RGN_LOG2);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        dat_q.delete();
        for (int k = 0; k < PIPE_DEPTH; k++) exp_q.push_back('0);
        for (int k = 0; k < DD; k++) dat_q.push_back('0);
        m_state = 0;
    endtask

    // One bus cycle: drive at posedge+1, check combinational outputs, clock, check stages.
    task automatic step(input logic rst, input logic rdy, input logic wr,
                        input logic [1:0] tr, input logic [31:0] a, input logic [31:0] d);
        logic        prr, v, errc, exp_rdy, exp_resp;
        logic [31:0] prd;
        stg_t        s;
        prr = 1'($urandom_range(0, 1));
        prd = $urandom;
        hreset        = rst;
        bus.hready_in = rdy;
        bus.hwrite    = wr;
        bus.htrans    = tr;
        bus.haddr     = a;
        bus.hwdata    = d;
        bus.pr_ready  = prr;
        bus.pr_data   = prd;
        #1;
        v        = rdy && tr[1] && m_inrange(a) && (m_state != 1);
        exp_rdy  = rst ? prr : (m_state == 1) ? 1'b0 : (m_state == 2) ? 1'b1 : prr;
        exp_resp = rst ? 1'b0 : (m_state != 0);
        chk("valid", 64'(bus.valid), 64'(v));
        chk("sel", 64'(bus.sel), 64'(m_sel(a)));
        chk("hr_data", 64'(bus.hr_data), 64'(prd));
        chk("hready_out", 64'(bus.hready_out), 64'(exp_rdy));
        chk("hresp", 64'(bus.hresp), 64'(exp_resp));
        @(posedge hclk);
        if (rst) begin
            model_reset();
        end else begin
            errc = rdy && tr[1] && !m_inrange(a);
            case (m_state)
                0:       m_state = errc ? 1 : 0;
                1:       m_state = 2;
                default: m_state = errc ? 1 : 0;
            endcase
            if (rdy) begin
                s.addr = a; s.wr = wr; s.sel = m_sel(a); s.vld = v;
                exp_q.push_back(s);
                void'(exp_q.pop_front());
                dat_q.push_back(d);
                void'(dat_q.pop_front());
            end
        end
        #1;
        chk("haddr_p", 64'(bus.haddr_p), 64'(exp_q[0].addr));
        chk("hwrite_p", 64'(bus.hwrite_p), 64'(exp_q[0].wr));
        chk("sel_p", 64'(bus.sel_p), 64'(exp_q[0].sel));
        chk("valid_p", 64'(bus.valid_p), 64'(exp_q[0].vld));
        chk("hwdata_p", 64'(bus.hwdata_p), 64'(dat_q[0]));
    endtask

    logic [31:0] hold_a, hold_d;

    initial begin
        hreset = 1'b1; bus.hready_in = 1'b1; bus.hwrite = 1'b0; bus.htrans = T_IDLE;
        bus.haddr = '0; bus.hwdata = '0; bus.pr_ready = 1'b1; bus.pr_data = '0;
        model_reset();
        @(posedge hclk); #1;
        step(1, 1, 0, T_NSEQ, 32'h8000_0000, 32'h1111_1111);
        chk("rst_valid_p", 64'(bus.valid_p), 64'd0);
        chk("rst_hresp", 64'(bus.hresp), 64'd0);

        // first write lands in region 1 and appears at the output two edges later
        step(0, 1, 1, T_NSEQ, 32'h8400_0010, 32'hA5A5_0001);
        chk("req040_sel", 64'(bus.sel), 64'h2);
        step(0, 1, 0, T_IDLE, 32'h0000_0000, 32'hDEAD_BEEF);
        chk("req040_haddr_p", 64'(bus.haddr_p), 64'h8400_0010);
        chk("req040_hwrite_p", 64'(bus.hwrite_p), 64'd1);
        chk("req040_sel_p", 64'(bus.sel_p), 64'h2);
        chk("req040_hwdata_p", 64'(bus.hwdata_p), 64'hDEAD_BEEF);

        // out of range -> ERR1 then ERR2 then OKAY
        step(0, 1, 0, T_NSEQ, 32'h9000_0000, 32'h0);
        chk("req041_hready_e1", 64'(bus.hready_out), 64'd0);
        chk("req041_hresp_e1", 64'(bus.hresp), 64'd1);
        step(0, 1, 0, T_IDLE, 32'h9000_0000, 32'h0);
        chk("req041_hready_e2", 64'(bus.hready_out), 64'd1);
        chk("req041_hresp_e2", 64'(bus.hresp), 64'd1);
        step(0, 1, 0, T_IDLE, 32'h9000_0000, 32'h0);
        chk("req041_hresp_ok", 64'(bus.hresp), 64'd0);

        // error during ERR2 restarts the two-cycle response
        step(0, 1, 0, T_NSEQ, 32'h9000_0000, 32'h0);
        step(0, 1, 0, T_IDLE, 32'h0, 32'h0);
        step(0, 1, 0, T_SEQ, 32'h8C00_0000, 32'h0);
        chk("req042_hresp", 64'(bus.hresp), 64'd1);
        chk("req042_hready", 64'(bus.hready_out), 64'd0);
        step(0, 1, 0, T_IDLE, 32'h0, 32'h0);
        // in-range transfer in ERR2 is accepted
        step(0, 1, 1, T_NSEQ, 32'h8000_0100, 32'h0);
        step(0, 1, 0, T_IDLE, 32'h0, 32'h2222_2222);
        chk("req034_valid_p", 64'(bus.valid_p), 64'd1);

        // stall for three cycles mid-stream
        step(0, 1, 1, T_NSEQ, 32'h8000_0200, 32'h3333_3333);
        step(0, 1, 1, T_SEQ, 32'h8000_0204, 32'h4444_4444);
        hold_a = bus.haddr_p;
        hold_d = bus.hwdata_p;
        for (int k = 0; k < 3; k++) step(0, 0, 1, T_SEQ, 32'h8000_0208, 32'h5555_5555);
        chk("req043_hold_a", 64'(bus.haddr_p), 64'(hold_a));
        chk("req043_hold_d", 64'(bus.hwdata_p), 64'(hold_d));
        step(0, 1, 1, T_SEQ, 32'h8000_0208, 32'h5555_5555);
        chk("req043_resume_a", 64'(bus.haddr_p), 64'h8000_0204);
        step(0, 1, 0, T_IDLE, 32'h0, 32'h6666_6666);

        // reset during ERR1
        step(0, 1, 0, T_NSEQ, 32'h9000_0000, 32'h0);
        step(1, 1, 0, T_IDLE, 32'h0, 32'h0);
        chk("req044_hresp", 64'(bus.hresp), 64'd0);
        chk("req044_haddr_p", 64'(bus.haddr_p), 64'd0);
        chk("req044_valid_p", 64'(bus.valid_p), 64'd0);
        step(0, 1, 0, T_IDLE, 32'h0, 32'h0);
        chk("req044_idle", 64'(bus.hresp), 64'd0);

        // BUSY never errors, below-base does, top-of-range selects region 2
        step(0, 1, 0, T_BUSY, 32'h9000_0000, 32'h0);
        chk("req045_busy", 64'(bus.hresp), 64'd0);
        step(0, 1, 0, T_NSEQ, 32'h7FFF_FFFC, 32'h0);
        chk("req045_low_err", 64'(bus.hresp), 64'd1);
        step(0, 1, 0, T_IDLE, 32'h0, 32'h0);
        step(0, 1, 0, T_NSEQ, 32'h8BFF_FFFC, 32'h0);
        chk("req045_top_sel", 64'(bus.sel), 64'h4);

        // randomised traffic around region boundaries
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0: a = 32'h7FFF_FFFC;
                1: a = BASE;
                2: a = 32'h83FF_FFFC;
                3: a = 32'h8400_0000;
                4: a = 32'h8BFF_FFFC;
                5: a = 32'h8C00_0000;
                6: a = BASE + ($urandom & 32'h0BFF_FFFC);
                default: a = $urandom;
            endcase
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ahb_slave_if_gen.md
AHB_SLAVE_IF_GEN -- requirements
Module: ahb_slave_if_gen

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width in bits.
REQ-002 SHALL have parameter DATA_W, 32, data width in bits.
REQ-003 SHALL have parameter NUM_SLV, 3, number of APB slave regions (1..8).
REQ-004 SHALL have parameter BASE_ADDR, 32'h8000_0000, start address of region 0.
REQ-005 SHALL have parameter RGN_LOG2, 26, log2 of each region size in bytes; region i spans BASE_ADDR+i*2^RGN_LOG2 up to but excluding BASE_ADDR+(i+1)*2^RGN_LOG2.
REQ-006 SHALL have parameter PIPE_DEPTH, 2, number of address/control/data pipeline stages (1..4).
REQ-007 SHALL have port hclk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port hreset, input, 1, reset; synchronous and active-high.
REQ-009 SHALL have port hwrite, input, 1, AHB write control.
REQ-010 SHALL have port hready_in, input, 1, AHB bus ready.
REQ-011 SHALL have port htrans, input, 2, transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-012 SHALL have port haddr, input, ADDR_W, AHB address.
REQ-013 SHALL have port hwdata, input, DATA_W, AHB write data.
REQ-014 SHALL have port pr_data, input, DATA_W, read data from the APB side.
REQ-015 SHALL have port pr_ready, input, 1, APB side ready.
REQ-016 SHALL have port valid, output, 1, qualified in-range transfer this cycle (combinational).
REQ-017 SHALL have port sel, output, NUM_SLV, one-hot region select for haddr (combinational).
REQ-018 SHALL have ports haddr_p / hwdata_p / hwrite_p / sel_p / valid_p, output, ADDR_W / DATA_W / 1 / NUM_SLV / 1, final pipeline stage values.
REQ-019 SHALL have port hr_data, output, DATA_W, read data returned to the master.
REQ-020 SHALL have port hready_out, output, 1, slave ready to the master.
REQ-021 SHALL have port hresp, output, 1, 0 = OKAY, 1 = ERROR.

Function
REQ-022 in_range SHALL be true iff BASE_ADDR <= haddr < BASE_ADDR + NUM_SLV*2^RGN_LOG2; the comparison SHALL be done at ADDR_W+1 bits so the end bound cannot wrap.
REQ-023 sel SHALL have bit i set iff haddr falls in region i, and SHALL be all-zero when not in_range.
REQ-024 valid SHALL equal hready_in & htrans[1] & in_range & (state != ERR1).
REQ-025 The pipeline SHALL advance one stage per clock only when hready_in=1 and SHALL hold all stages otherwise.
REQ-026 Stage 1 SHALL capture haddr, hwrite, sel and valid; stage k SHALL capture stage k-1; outputs SHALL be taken from stage PIPE_DEPTH.
REQ-027 The hwdata pipeline SHALL lag the address pipeline by one stage: hwdata_p is the data captured PIPE_DEPTH-1 enables after the address stage-1 capture. For PIPE_DEPTH=1, hwdata_p SHALL be hwdata registered once.
REQ-028 hr_data SHALL equal pr_data combinationally.
REQ-029 The FSM SHALL have states IDLE, ERR1 and ERR2.
REQ-030 IDLE SHALL go to ERR1 when hready_in=1, htrans[1]=1 and not in_range; otherwise it SHALL stay in IDLE.
REQ-031 ERR1 SHALL go to ERR2 unconditionally.
REQ-032 ERR2 SHALL go to ERR1 if the REQ-030 error condition holds again; otherwise it SHALL go to IDLE.
REQ-033 In IDLE: hready_out=pr_ready, hresp=0. In ERR1: hready_out=0, hresp=1. In ERR2: hready_out=1, hresp=1.
REQ-034 An in-range transfer sampled in ERR2 SHALL be accepted normally (valid=1, pipelined).
REQ-035 BUSY and IDLE htrans SHALL never produce valid or an error.
REQ-036 An out-of-range transfer SHALL load valid=0 and sel=0 into stage 1.

Reset
REQ-037 With hreset=1 at a rising edge: all pipeline stages SHALL be 0 and the FSM SHALL be IDLE.
REQ-038 Reset SHALL override hready_in gating and any in-progress error response, so the FSM is IDLE on the next cycle.
REQ-039 During and after reset: hresp=0 and hready_out=pr_ready.

Verification (defaults: NUM_SLV=3, valid range 0x8000_0000..0x8BFF_FFFF)
REQ-040 Stimulus: NONSEQ write at haddr 0x8400_0010, hready_in=1. Required: valid=1, sel=3'b010. Two edges later, with PIPE_DEPTH=2: haddr_p=0x8400_0010, hwrite_p=1, sel_p=3'b010.
REQ-041 Stimulus: NONSEQ at 0x9000_0000. Required: valid=0, sel=0; next cycle hready_out=0, hresp=1; the cycle after, hready_out=1, hresp=1; then OKAY.
REQ-042 Stimulus: back-to-back out-of-range SEQ at 0x8C00_0000, presented during ERR2. Required: ERR2 goes to ERR1, giving a second two-cycle error.
REQ-043 Stimulus: hready_in=0 for 3 cycles mid-stream. Required: haddr_p, hwdata_p and valid_p hold; they resume exactly one stage per enabled edge.
REQ-044 Stimulus: hreset asserted during ERR1. Required: next cycle FSM is IDLE, hresp=0, and all *_p outputs are 0.
REQ-045 Stimulus: htrans=BUSY at 0x9000_0000, and separately haddr 0x7FFF_FFFC with NONSEQ. Required: BUSY gives no error; 0x7FFF_FFFC gives an error; address 0x8BFF_FFFC gives sel=3'b100.
